// File: rtl/pipe_stage_buf.sv
// Generic handshaked pipeline-stage buffer with flush, bubble insertion and
// an optional two-entry skid mode that registers the upstream ready.
module pipe_stage_buf #(
  parameter int unsigned      WIDTH  = 32,
  parameter int unsigned      SKID   = 0,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       level
);

  if (SKID == 0) begin : gSingle
    logic             mValid;
    logic             mValidNext;
    logic [WIDTH-1:0] mData;
    logic [WIDTH-1:0] mDataNext;
    logic             accept;
    logic             pop;

    // A full register can still take a new payload when the head leaves this cycle.
    assign in_ready = ~mValid | out_ready;
    assign accept   = in_valid & in_ready;
    assign pop      = mValid & out_ready;

    // Next-state: flush wins, then load, then drain back to the bubble.
    always_comb begin
      mValidNext = mValid;
      mDataNext  = mData;
      if (flush) begin
        mValidNext = 1'b0;
        mDataNext  = BUBBLE;
      end else if (accept) begin
        mValidNext = 1'b1;
        mDataNext  = in_data;
      end else if (pop) begin
        mValidNext = 1'b0;
        mDataNext  = BUBBLE;
      end
    end

    // Stage register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mValid <= 1'b0;
        mData  <= BUBBLE;
      end else begin
        mValid <= mValidNext;
        mData  <= mDataNext;
      end
    end

    assign out_valid = mValid;
    assign out_data  = mData;
    assign level     = {1'b0, mValid};

  end else begin : gSkid
    // Encoding equals the number of held entries so level is a plain register decode.
    typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
    } stateT;

    stateT            state;
    stateT            stateNext;
    logic [WIDTH-1:0] mData;
    logic [WIDTH-1:0] mDataNext;
    logic [WIDTH-1:0] sData;
    logic [WIDTH-1:0] sDataNext;
    logic             accept;
    logic             pop;

    // Ready depends only on the state register, cutting the out_ready path.
    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign out_data  = mData;
    assign level     = state;
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Next-state and payload steering; invalid slots are refilled with the bubble.
    always_comb begin
      stateNext = state;
      mDataNext = mData;
      sDataNext = sData;
      if (flush) begin
        stateNext = EMPTY;
        mDataNext = BUBBLE;
        sDataNext = BUBBLE;
      end else begin
        case (state)
          EMPTY: begin
            if (accept) begin
              stateNext = ONE;
              mDataNext = in_data;
            end
          end
          ONE: begin
            if (accept && !pop) begin
              stateNext = TWO;
              sDataNext = in_data;
            end else if (accept && pop) begin
              mDataNext = in_data;
            end else if (pop) begin
              stateNext = EMPTY;
              mDataNext = BUBBLE;
            end
          end
          TWO: begin
            if (pop) begin
              stateNext = ONE;
              mDataNext = sData;
              sDataNext = BUBBLE;
            end
          end
          default: begin
            stateNext = EMPTY;
            mDataNext = BUBBLE;
            sDataNext = BUBBLE;
          end
        endcase
      end
    end

    // State and payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= EMPTY;
        mData <= BUBBLE;
        sData <= BUBBLE;
      end else begin
        state <= stateNext;
        mData <= mDataNext;
        sData <= sDataNext;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed checks on 32-bit single/skid stages plus a
// queue scoreboard over five instances of different widths and modes.
module tb_pipe_stage_buf;

  localparam int unsigned NDUT = 5;
  localparam int unsigned MAXW = 200;
  localparam int unsigned WS [NDUT] = '{32, 32, 1, 143, 200};
  localparam int unsigned SK [NDUT] = '{0, 1, 1, 0, 1};
  localparam logic [MAXW-1:0] BUB = 200'h13;

  logic            clk;
  logic            rst_n;
  logic            flush    [NDUT];
  logic            inValid  [NDUT];
  logic            inReady  [NDUT];
  logic [MAXW-1:0] inData   [NDUT];
  logic            outValid [NDUT];
  logic            outReady [NDUT];
  logic [MAXW-1:0] outData  [NDUT];
  logic [1:0]      lvl      [NDUT];

  logic [MAXW-1:0] expQ [NDUT][$];
  int nCmp;
  int nErr;

  for (genvar k = 0; k < NDUT; k++) begin : gDut
    localparam int unsigned W = WS[k];
    logic [W-1:0] od;
    logic [1:0]   lv;
    logic         ir;
    logic         ov;

    pipe_stage_buf #(
      .WIDTH (W),
      .SKID  (SK[k]),
      .BUBBLE(BUB[W-1:0])
    ) u (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush[k]),
      .in_valid (inValid[k]),
      .in_ready (ir),
      .in_data  (inData[k][W-1:0]),
      .out_valid(ov),
      .out_ready(outReady[k]),
      .out_data (od),
      .level    (lv)
    );

    assign outData[k]  = MAXW'(od);
    assign inReady[k]  = ir;
    assign outValid[k] = ov;
    assign lvl[k]      = lv;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [MAXW-1:0] maskOf(int unsigned w);
    return (200'd1 << w) - 200'd1;
  endfunction

  task automatic chk(string name, logic [MAXW-1:0] act, logic [MAXW-1:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: checks held state against the queue, pops on out
  // transfers, pushes on accepts, and empties the queue on flush or reset.
  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
        if (!rst_n) begin
          expQ[k].delete();
          continue;
        end
        chk($sformatf("u%0d level", k), MAXW'(lvl[k]), MAXW'(expQ[k].size()));
        chk($sformatf("u%0d out_valid", k), MAXW'(outValid[k]), MAXW'(expQ[k].size() != 0));
        if (SK[k] != 0)
          chk($sformatf("u%0d in_ready", k), MAXW'(inReady[k]), MAXW'(expQ[k].size() < 2));
        else
          chk($sformatf("u%0d in_ready", k), MAXW'(inReady[k]),
              MAXW'(expQ[k].size() == 0 || outReady[k]));
        if (outValid[k] && expQ[k].size() > 0) begin
          chk($sformatf("u%0d out_data", k), outData[k], expQ[k][0]);
          if (outReady[k]) void'(expQ[k].pop_front());
        end else if (!outValid[k]) begin
          chk($sformatf("u%0d bubble", k), outData[k], BUB & maskOf(WS[k]));
        end
        if (flush[k]) expQ[k].delete();
        else if (inValid[k] && inReady[k]) expQ[k].push_back(inData[k] & maskOf(WS[k]));
      end
    end
  endtask

  initial begin
    nCmp  = 0;
    nErr  = 0;
    rst_n = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      flush[k]    = 1'b0;
      inValid[k]  = 1'b0;
      inData[k]   = '0;
      outReady[k] = 1'b1;
    end
    fork
      monitor();
    join_none
    repeat (3) step();
    rst_n = 1'b1;

    // Reset state, with out_ready low so in_ready=1 comes from emptiness alone.
    outReady[0] = 1'b0;
    outReady[1] = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst u%0d level", k), MAXW'(lvl[k]), 200'd0);
      chk($sformatf("rst u%0d out_valid", k), MAXW'(outValid[k]), 200'd0);
      chk($sformatf("rst u%0d out_data", k), outData[k], 200'h13);
      chk($sformatf("rst u%0d in_ready", k), MAXW'(inReady[k]), 200'd1);
    end
    outReady[0] = 1'b1;
    outReady[1] = 1'b1;

    // Streaming 1..16 through both 32-bit stages at full rate.
    inValid[0] = 1'b1; inData[0] = 200'd1;
    inValid[1] = 1'b1; inData[1] = 200'd1;
    for (int i = 1; i <= 16; i++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("stream u%0d data %0d", k, i), outData[k], MAXW'(i));
        chk($sformatf("stream u%0d level %0d", k, i), MAXW'(lvl[k]), 200'd1);
        chk($sformatf("stream u%0d in_ready %0d", k, i), MAXW'(inReady[k]), 200'd1);
        if (i < 16) inData[k] = MAXW'(i + 1);
        else inValid[k] = 1'b0;
      end
    end
    step();
    chk("stream u0 drained", MAXW'(lvl[0]), 200'd0);
    chk("stream u1 drained", MAXW'(lvl[1]), 200'd0);

    // Skid stall: 0xA, 0xB with out_ready low, then drain.
    inValid[1] = 1'b1; inData[1] = 200'hA; outReady[1] = 1'b0;
    step();
    chk("skid one level", MAXW'(lvl[1]), 200'd1);
    chk("skid one in_ready", MAXW'(inReady[1]), 200'd1);
    inData[1] = 200'hB;
    step();
    inValid[1] = 1'b0;
    chk("skid two level", MAXW'(lvl[1]), 200'd2);
    chk("skid two in_ready", MAXW'(inReady[1]), 200'd0);
    chk("skid two head", outData[1], 200'hA);
    outReady[1] = 1'b1;
    step();
    chk("skid drain1 data", outData[1], 200'hB);
    chk("skid drain1 level", MAXW'(lvl[1]), 200'd1);
    chk("skid drain1 in_ready", MAXW'(inReady[1]), 200'd1);
    step();
    chk("skid drain2 level", MAXW'(lvl[1]), 200'd0);
    chk("skid drain2 bubble", outData[1], 200'h13);

    // Single-register stall: hold 0xC, offer 0xD, then release.
    inValid[0] = 1'b1; inData[0] = 200'hC; outReady[0] = 1'b0;
    step();
    inData[0] = 200'hD;
    #1;
    chk("single stall in_ready", MAXW'(inReady[0]), 200'd0);
    chk("single stall head", outData[0], 200'hC);
    step();
    chk("single held head", outData[0], 200'hC);
    chk("single held level", MAXW'(lvl[0]), 200'd1);
    outReady[0] = 1'b1;
    #1;
    chk("single release in_ready", MAXW'(inReady[0]), 200'd1);
    step();
    inValid[0] = 1'b0;
    chk("single swap data", outData[0], 200'hD);
    chk("single swap level", MAXW'(lvl[0]), 200'd1);
    step();
    chk("single swap drained", MAXW'(lvl[0]), 200'd0);

    // Flush of a full skid buffer with a same-cycle offer of 0x1.
    inValid[1] = 1'b1; inData[1] = 200'hE; outReady[1] = 1'b0;
    step();
    inData[1] = 200'hF;
    step();
    chk("flush pre level", MAXW'(lvl[1]), 200'd2);
    flush[1] = 1'b1; inData[1] = 200'h1;
    step();
    flush[1] = 1'b0; inValid[1] = 1'b0; outReady[1] = 1'b1;
    chk("flush skid level", MAXW'(lvl[1]), 200'd0);
    chk("flush skid out_valid", MAXW'(outValid[1]), 200'd0);
    chk("flush skid bubble", outData[1], 200'h13);

    // Flush of the single register with a same-cycle delivery and accept.
    inValid[0] = 1'b1; inData[0] = 200'hE; outReady[0] = 1'b0;
    step();
    inData[0] = 200'h1; outReady[0] = 1'b1; flush[0] = 1'b1;
    step();
    flush[0] = 1'b0; inValid[0] = 1'b0;
    chk("flush single level", MAXW'(lvl[0]), 200'd0);
    chk("flush single bubble", outData[0], 200'h13);
    repeat (3) step();

    // Asynchronous reset mid-cycle with the skid buffer full.
    inValid[1] = 1'b1; inData[1] = 200'h77; outReady[1] = 1'b0;
    step();
    inData[1] = 200'h88;
    step();
    inValid[1] = 1'b0;
    chk("areset pre level", MAXW'(lvl[1]), 200'd2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("areset level", MAXW'(lvl[1]), 200'd0);
    chk("areset out_valid", MAXW'(outValid[1]), 200'd0);
    chk("areset bubble", outData[1], 200'h13);
    chk("areset in_ready", MAXW'(inReady[1]), 200'd1);
    step();
    rst_n = 1'b1;
    outReady[1] = 1'b1;
    step();

    // Random valid/ready/flush sweep across all widths; the monitor checks.
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < NDUT; k++) begin
        inValid[k]  = ($urandom_range(0, 3) != 0);
        outReady[k] = ($urandom_range(0, 2) != 0);
        flush[k]    = ($urandom_range(0, 15) == 0);
        inData[k]   = MAXW'({$urandom(), $urandom(), $urandom(), $urandom(),
                             $urandom(), $urandom(), $urandom()});
      end
      step();
    end
    for (int k = 0; k < NDUT; k++) begin
      inValid[k]  = 1'b0;
      outReady[k] = 1'b1;
      flush[k]    = 1'b0;
    end
    repeat (4) step();
    for (int k = 0; k < NDUT; k++)
      chk($sformatf("sweep u%0d drained", k), MAXW'(lvl[k]), 200'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
